// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID register.
// Owns the word-addressed fetch PC, keeps at most one request outstanding
// to a variable-latency instruction memory, buffers returned words in a
// small prefetch queue and presents one {instr, pcp1} per cycle.
// Optional macro IF_FETCH_BYPASS_EN: an accepted response drives the
// outputs combinationally while the queue is empty.
module if_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       QDEPTH   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr_f,
    output logic [ADDR_W-1:0] pcp1_f,
    output logic              valid_f
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_resp_pcp1;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [DATA_W-1:0] r_q_instr [QDEPTH];
    logic [ADDR_W-1:0] r_q_pcp1  [QDEPTH];

    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_qwr;
    logic              w_qrd;
    logic              w_room;
    logic              w_gnt;
    logic [CNT_W-1:0]  w_count_nxt;

    // Head of queue (or bypassed response) drives the IF/ID outputs.
    always_comb begin
        w_empty = (r_count == '0);
        w_push  = (r_state == S_WAIT) && imem_rvalid && !redirect;
        if (!w_empty) begin
            valid_f = 1'b1;
            instr_f = r_q_instr[r_rd_ptr];
            pcp1_f  = r_q_pcp1[r_rd_ptr];
        end
`ifdef IF_FETCH_BYPASS_EN
        else if (w_push) begin
            valid_f = 1'b1;
            instr_f = imem_rdata;
            pcp1_f  = r_resp_pcp1;
        end
`endif
        else begin
            valid_f = 1'b0;
            instr_f = '0;
            pcp1_f  = '0;
        end
    end

    // Queue bookkeeping: pop/push decisions, next occupancy and room.
    always_comb begin
        w_pop = valid_f && !stall && !redirect;
        w_qrd = w_pop && !w_empty;
`ifdef IF_FETCH_BYPASS_EN
        // A bypassed word consumed in the same cycle never enters the queue.
        w_qwr = w_push && !(w_empty && w_pop);
`else
        w_qwr = w_push;
`endif
        w_count_nxt = r_count + CNT_W'(w_qwr) - CNT_W'(w_qrd);
        w_room      = (w_count_nxt < CNT_W'(QDEPTH));
    end

    // Memory request: steady in REQ, back-to-back from WAIT when room remains.
    always_comb begin
        imem_req  = !rst && ((r_state == S_REQ) ||
                             ((r_state == S_WAIT) && w_push && w_room));
        imem_addr = r_fetch_pc;
        w_gnt     = imem_req && imem_gnt;
    end

    // Queue storage; contents are qualified by r_count so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_qwr) begin
            r_q_instr[r_wr_ptr] <= imem_rdata;
            r_q_pcp1[r_wr_ptr]  <= r_resp_pcp1;
        end
    end

    // Fetch FSM, fetch PC, response tag and queue pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_REQ;
            r_fetch_pc  <= RESET_PC;
            r_resp_pcp1 <= '0;
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
        end else begin
            if (w_gnt) begin
                r_resp_pcp1 <= r_fetch_pc + ADDR_W'(1);
            end

            if (redirect) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_gnt) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
            end

            if (redirect) begin
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                r_count <= w_count_nxt;
                if (w_qwr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_qrd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end

            unique case (r_state)
                S_IDLE: begin
                    if (redirect || (r_count < CNT_W'(QDEPTH))) r_state <= S_REQ;
                end
                S_REQ: begin
                    if (redirect) begin
                        r_state <= w_gnt ? S_DROP : S_REQ;
                    end else if (w_gnt) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (redirect)     r_state <= S_REQ;
                        else if (!w_room) r_state <= S_IDLE;
                        else if (w_gnt)   r_state <= S_WAIT;
                        else              r_state <= S_REQ;
                    end else if (redirect) begin
                        r_state <= S_DROP;
                    end
                end
                S_DROP: begin
                    // A redirect here only retargets the PC; the stale
                    // response must still be absorbed before requesting.
                    if (imem_rvalid) r_state <= S_REQ;
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: randomized memory latency/grant, stalls,
// redirects and resets against a stream-level reference model, plus
// directed scenarios with literal expectations.
module tb_if_fetch_unit;

    localparam int unsigned QD  = 2;
    localparam logic [31:0] RPC = 32'h10;
`ifdef IF_FETCH_BYPASS_EN
    localparam int FIRST_LAT = 1;
`else
    localparam int FIRST_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr_f;
    logic [31:0] pcp1_f;
    logic        valid_f;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .QDEPTH   (QD),
        .RESET_PC (RPC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_f     (instr_f),
        .pcp1_f      (pcp1_f),
        .valid_f     (valid_f)
    );

    int total = 0;
    int bad   = 0;

    // stimulus knobs for the next cycle
    logic        rst_v = 1'b1;
    logic        stall_v = 1'b0;
    logic        redir_v = 1'b0;
    logic [31:0] rpc_v = '0;
    int unsigned gnt_prob = 100;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;

    // memory model: one pending response
    logic        mem_busy = 1'b0;
    int unsigned mem_left = 0;
    logic [31:0] mem_addr = '0;

    // reference model: next PC to be delivered, next PC to be requested
    logic [31:0] exp_pc = RPC;
    logic [31:0] fetch_exp = RPC;
    int unsigned idle_run = 0;

    // per-cycle samples
    logic        s_req, s_grant, s_valid, s_rvalid;
    logic [31:0] s_addr, s_pcp1, s_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0DE0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the edge, then sample and check.
    task automatic cycle();
        @(posedge clk);
        #1;
        rst         = rst_v;
        stall       = stall_v;
        redirect    = redir_v;
        redirect_pc = rpc_v;
        imem_gnt    = ($urandom_range(99) < gnt_prob);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom();
        if (rst_v) begin
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            if (mem_left == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
            end else begin
                mem_left--;
            end
        end
        #1;
        s_req    = imem_req;
        s_addr   = imem_addr;
        s_grant  = imem_req & imem_gnt;
        s_valid  = valid_f;
        s_pcp1   = pcp1_f;
        s_instr  = instr_f;
        s_rvalid = imem_rvalid;
        if (rst_v) begin
            check("req_in_reset", 32'(s_req), 32'd0);
            exp_pc    = RPC;
            fetch_exp = RPC;
            idle_run  = 0;
        end else begin
            if (s_valid) begin
                check("pcp1_f", s_pcp1, exp_pc + 32'd1);
                check("instr_f", s_instr, mem_word(exp_pc));
            end else begin
                check("empty_instr", s_instr, 32'd0);
                check("empty_pcp1", s_pcp1, 32'd0);
            end
            if (s_rvalid) mem_busy = 1'b0;
            if (s_grant) begin
                check("one_outstanding", 32'(mem_busy), 32'd0);
                check("grant_addr", s_addr, fetch_exp);
                mem_busy  = 1'b1;
                mem_left  = $urandom_range(lat_max, lat_min) - 1;
                mem_addr  = s_addr;
                fetch_exp = fetch_exp + 32'd1;
            end
            if (s_valid && !stall_v && !redir_v) exp_pc = exp_pc + 32'd1;
            if (redir_v) begin
                exp_pc    = rpc_v;
                fetch_exp = rpc_v;
            end
            check("fetch_ahead", 32'((fetch_exp - exp_pc) <= 32'(QD)), 32'd1);
            if (stall_v || redir_v || s_valid) idle_run = 0;
            else idle_run++;
            if (idle_run >= 80) begin
                check("progress", 32'd0, 32'd1);
                idle_run = 0;
            end
        end
    endtask

    initial begin
        logic [31:0] a_q [6];
        logic        r_q [6];
        logic        v_q [6];
        logic [31:0] p_q [6];
        logic [31:0] hold_p, hold_i;
        logic        found;

        // ---- reset ----
        rst_v = 1'b1;
        cycle();
        cycle();
        check("rst_valid", 32'(s_valid), 32'd0);
        check("rst_instr", s_instr, 32'd0);
        check("rst_pcp1", s_pcp1, 32'd0);

        // ---- first fetches, 1-cycle memory ----
        rst_v = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            a_q[c] = s_addr; r_q[c] = s_req; v_q[c] = s_valid; p_q[c] = s_pcp1;
        end
        for (int c = 0; c < 3; c++) begin
            check("boot_req", 32'(r_q[c]), 32'd1);
            check("boot_addr", a_q[c], RPC + 32'(c));
        end
        check("first_valid_before", 32'(v_q[FIRST_LAT-1]), 32'd0);
        check("first_valid_at", 32'(v_q[FIRST_LAT]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("boot_pcp1", p_q[FIRST_LAT+k], 32'h11 + 32'(k));
        end

        // ---- stall 5 cycles mid-stream ----
        stall_v = 1'b1;
        cycle();
        check("stall_head_valid", 32'(s_valid), 32'd1);
        hold_p = s_pcp1;
        hold_i = s_instr;
        for (int c = 0; c < 4; c++) begin
            cycle();
            check("stall_hold_pcp1", s_pcp1, hold_p);
            check("stall_hold_instr", s_instr, hold_i);
        end
        check("stall_req_off", 32'(s_req), 32'd0);
        check("stall_queue_full", fetch_exp - exp_pc, 32'(QD));
        stall_v = 1'b0;
        repeat (10) cycle();

        // ---- redirect while WAIT, 3-cycle memory ----
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            cycle();
            found = s_grant;
        end
        check("wait_grant_seen", 32'(found), 32'd1);
        redir_v = 1'b1; rpc_v = 32'h40;
        cycle();
        check("redir_wait_noreq", 32'(s_req), 32'd0);
        redir_v = 1'b0;
        cycle();
        check("drop_noreq", 32'(s_req), 32'd0);
        cycle();
        check("drop_stale_noreq", 32'(s_req), 32'd0);
        cycle();
        check("drop_then_req", 32'(s_req), 32'd1);
        check("drop_then_addr", s_addr, 32'h40);
        found = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            cycle();
            found = s_valid;
        end
        check("after_drop_valid", 32'(found), 32'd1);
        check("after_drop_pcp1", s_pcp1, 32'h41);

        // ---- redirect coincident with rvalid ----
        lat_min = 2; lat_max = 2;
        repeat (3) cycle();
        for (int c = 0; c < 20 && !(mem_busy && mem_left == 0); c++) cycle();
        check("rvalid_pending", 32'(mem_busy && mem_left == 0), 32'd1);
        redir_v = 1'b1; rpc_v = 32'h80;
        cycle();
        check("redir_rvalid_noreq", 32'(s_req), 32'd0);
        redir_v = 1'b0;
        cycle();
        check("redir_rvalid_req", 32'(s_req), 32'd1);
        check("redir_rvalid_addr", s_addr, 32'h80);
        check("redir_rvalid_flush", 32'(s_valid), 32'd0);

        // ---- redirect while REQ is ungranted ----
        gnt_prob = 0;
        repeat (8) cycle();
        check("ungranted_req", 32'(s_req), 32'd1);
        redir_v = 1'b1; rpc_v = 32'hC0;
        cycle();
        redir_v = 1'b0;
        cycle();
        check("ungranted_retarget_req", 32'(s_req), 32'd1);
        check("ungranted_retarget_addr", s_addr, 32'hC0);
        gnt_prob = 100; lat_min = 1; lat_max = 1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            cycle();
            found = s_valid;
        end
        check("retarget_valid", 32'(found), 32'd1);
        check("retarget_pcp1", s_pcp1, 32'hC1);

        // ---- randomized segments ----
        for (int seg = 0; seg < 8; seg++) begin
            int unsigned stall_pct, redir_pct;
            gnt_prob  = (seg % 4 == 0) ? 100 : $urandom_range(90, 30);
            lat_min   = 1;
            lat_max   = (seg % 3 == 0) ? 1 : $urandom_range(4, 2);
            stall_pct = (seg % 2 == 0) ? 0 : $urandom_range(50, 10);
            redir_pct = $urandom_range(6, 0);
            for (int c = 0; c < 400; c++) begin
                stall_v = ($urandom_range(99) < stall_pct);
                redir_v = ($urandom_range(99) < redir_pct);
                rpc_v   = $urandom();
                rst_v   = ($urandom_range(999) == 0);
                cycle();
            end
        end
        stall_v = 1'b0; redir_v = 1'b0; rst_v = 1'b0;
        repeat (5) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
